// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - byte-enabled data-memory responder with request/response handshakes
module dmem_responder #(
  parameter int    DEPTH_WORDS = 1024,
  parameter int    WAIT_CYCLES = 1,
  parameter string MEMORY_FILE = ""
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_be_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_error_o
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state, state_next;
  logic        accept, commit;
  logic [3:0]  wait_cnt;
  logic        write_q;
  logic [29:0] idx_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        be_legal, idx_legal, access_ok;
  logic [31:0] lane_mask;
  logic        unused_addr_bits;

  logic [31:0] mem [DEPTH_WORDS];

  assign unused_addr_bits = ^req_addr_i[1:0];

  // Both handshake outputs decode directly from the state register.
  assign req_ready_o = (state == IDLE);
  assign rsp_valid_o = (state == RESP);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid_i) begin
          accept     = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        if (wait_cnt == 4'd0) begin
          commit     = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    be_legal = 1'b0;
    case (be_q)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: be_legal = 1'b1;
      default:                   be_legal = 1'b0;
    endcase
  end

  assign idx_legal = ({2'b00, idx_q} < 32'(DEPTH_WORDS));
  assign access_ok = be_legal && idx_legal;
  assign lane_mask = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_cnt    <= 4'd0;
      write_q     <= 1'b0;
      idx_q       <= 30'd0;
      wdata_q     <= 32'd0;
      be_q        <= 4'd0;
      rsp_rdata_o <= 32'd0;
      rsp_error_o <= 1'b0;
    end else if (accept) begin
      wait_cnt <= 4'(WAIT_CYCLES);
      write_q  <= req_write_i;
      idx_q    <= req_addr_i[31:2];
      wdata_q  <= req_wdata_i;
      be_q     <= req_be_i;
    end else if (commit) begin
      rsp_error_o <= !access_ok;
      rsp_rdata_o <= (access_ok && !write_q) ? (mem[idx_q[AW-1:0]] & lane_mask) : 32'd0;
    end else if (state == ACCESS) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // RAM has no reset; commit is only possible from ACCESS, which reset leaves immediately.
  always_ff @(posedge clk_i) begin
    if (commit && access_ok && write_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem[idx_q[AW-1:0]][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule
